// File: rtl/md5_pkg.sv
// Shared MD5 definitions: FSM state type, standard IV words and the
// per-step shift-amount and message-index helpers.
package md5_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  function automatic logic [4:0] shift_amt(input logic [5:0] step);
    logic [4:0] s;
    s = '0;
    case ({step[5:4], step[1:0]})
      4'b00_00: s = 5'd7;
      4'b00_01: s = 5'd12;
      4'b00_10: s = 5'd17;
      4'b00_11: s = 5'd22;
      4'b01_00: s = 5'd5;
      4'b01_01: s = 5'd9;
      4'b01_10: s = 5'd14;
      4'b01_11: s = 5'd20;
      4'b10_00: s = 5'd4;
      4'b10_01: s = 5'd11;
      4'b10_10: s = 5'd16;
      4'b10_11: s = 5'd23;
      4'b11_00: s = 5'd6;
      4'b11_01: s = 5'd10;
      4'b11_10: s = 5'd15;
      default:  s = 5'd21;
    endcase
    return s;
  endfunction

  // Only i mod 16 matters for the mod-16 index, so 4-bit arithmetic suffices.
  function automatic logic [3:0] msg_idx(input logic [5:0] step);
    logic [3:0] j;
    logic [3:0] g;
    j = step[3:0];
    g = '0;
    case (step[5:4])
      2'd0:    g = j;
      2'd1:    g = j * 4'd5 + 4'd1;
      2'd2:    g = j * 4'd3 + 4'd5;
      default: g = j * 4'd7;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: mixes A..D with M[g] and K for step index i
// and returns the rotated next working registers.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [31:0] k,
  input  logic [5:0]  step,
  output logic [31:0] next_a,
  output logic [31:0] next_b,
  output logic [31:0] next_c,
  output logic [31:0] next_d
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [31:0] rot;
  logic [4:0]  sh;

  always_comb begin
    f = '0;
    case (step[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    sh     = shift_amt(step);
    sum    = a + f + k + m;
    rot    = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));
    next_a = d;
    next_b = b + rot;
    next_c = b;
    next_d = c;
  end

endmodule

// File: rtl/md5_round_engine.sv
// Iterative MD5 compression: 64 steps at one per clock, then chaining add.
// Optional MD5_ENGINE_IV_EN adds use_iv to substitute the standard IV for chain_in.
module md5_round_engine
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef MD5_ENGINE_IV_EN
  input  logic         use_iv,
`endif
  input  logic [511:0] msg_block,
  input  logic [127:0] chain_in,
  output logic [5:0]   k_addr,
  input  logic [31:0]  k_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] digest_out
);

  state_t       state;
  logic [511:0] msg;
  logic [127:0] chain;
  logic [127:0] init_chain;
  logic [31:0]  a, b, c, d;
  logic [31:0]  next_a, next_b, next_c, next_d;
  logic [31:0]  m_word;
  logic [8:0]   m_base;
  logic [5:0]   step;

  assign k_addr = step;

`ifdef MD5_ENGINE_IV_EN
  assign init_chain = use_iv ? {IV_D, IV_C, IV_B, IV_A} : chain_in;
`else
  assign init_chain = chain_in;
`endif

  always_comb begin
    m_base = {msg_idx(step), 5'b0};
    m_word = msg[m_base +: 32];
  end

  md5_step u_step (
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .m      (m_word),
    .k      (k_data),
    .step   (step),
    .next_a (next_a),
    .next_b (next_b),
    .next_c (next_c),
    .next_d (next_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      msg        <= '0;
      chain      <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      step       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      digest_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            msg          <= msg_block;
            chain        <= init_chain;
            {d, c, b, a} <= init_chain;
            step         <= '0;
            busy         <= 1'b1;
            state        <= ROUND;
          end
        end
        ROUND: begin
          a    <= next_a;
          b    <= next_b;
          c    <= next_c;
          d    <= next_d;
          // 6-bit counter wraps 63 -> 0, leaving k_addr at 0 in FINAL/IDLE
          step <= step + 6'd1;
          if (step == 6'd63) state <= FINAL;
        end
        FINAL: begin
          digest_out <= {chain[127:96] + d, chain[95:64] + c,
                         chain[63:32] + b, chain[31:0] + a};
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
